param_bus_arbiter: RTL and testbench

- Shares the single read/write port of the parameter RAM between the DSP core (read-only, highest priority, never stalled) and the host CPU (writes only, back-pressured).
- Host writes are buffered in a small FIFO and retired into RAM on cycles where the DSP issues no read.
- Sits between the DSP param bus and the parameter RAM; the DSP sees the same 1-cycle read latency as a dedicated RAM.

---
 rtl/param_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_param_bus_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_bus_arbiter.sv
// Parameter RAM port arbiter: DSP reads always win, host writes are FIFO-buffered and retire on idle cycles.
// DSP read latency 1 cycle; host back-pressured by cpu_wr_ready; PARAM_ATOMIC_COMMIT_EN enables frame-aligned group commit.

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int LVL_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        level <= level + 1'b1;
      else if (do_pop && !do_push)
        level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module param_bus_arbiter #(
  parameter int PARAM_WIDTH      = 36,
  parameter int PARAM_ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH       = 8,
  parameter int LVL_WIDTH        = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        dsp_rd_en,
  input  logic [PARAM_ADDR_WIDTH-1:0] dsp_rd_addr,
  output logic [PARAM_WIDTH-1:0]      dsp_rd_data,
  input  logic                        cpu_wr_valid,
  output logic                        cpu_wr_ready,
  input  logic [PARAM_ADDR_WIDTH-1:0] cpu_wr_addr,
  input  logic [PARAM_WIDTH-1:0]      cpu_wr_data,
  input  logic                        cpu_commit,
  input  logic                        frame_start,
  output logic [PARAM_ADDR_WIDTH-1:0] ram_addr,
  output logic                        ram_rd_en,
  output logic                        ram_wr_en,
  output logic [PARAM_WIDTH-1:0]      ram_wr_data,
  input  logic [PARAM_WIDTH-1:0]      ram_rd_data,
  output logic [LVL_WIDTH-1:0]        fifo_level,
  output logic [15:0]                 defer_count
);
  typedef struct packed {
    logic [PARAM_ADDR_WIDTH-1:0] addr;
    logic [PARAM_WIDTH-1:0]      data;
  } wr_entry_t;

  wr_entry_t push_entry;
  wr_entry_t head;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  logic      eligible;

  assign push_entry   = '{addr: cpu_wr_addr, data: cpu_wr_data};
  assign cpu_wr_ready = !full;
  assign push         = cpu_wr_valid && cpu_wr_ready;
  assign pop          = ram_wr_en;
  assign dsp_rd_data  = ram_rd_data;

  sync_fifo #(
    .WIDTH ($bits(wr_entry_t)),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_WIDTH)
  ) u_wr_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .head_dat (head),
    .level    (fifo_level),
    .full     (full),
    .empty    (empty)
  );

`ifdef PARAM_ATOMIC_COMMIT_EN
  typedef enum logic [1:0] {IDLE, ARMED, DRAIN} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [LVL_WIDTH-1:0] commit_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      commit_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cpu_commit && !empty)
        commit_cnt <= fifo_level;
      else if (state == DRAIN && pop)
        commit_cnt <= commit_cnt - 1'b1;
    end
  end

  // A commit with nothing buffered is a no-op; a same-cycle frame_start only arms.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_commit && !empty) state_nxt = ARMED;
      ARMED:   if (frame_start) state_nxt = DRAIN;
      DRAIN:   if (commit_cnt == '0 || (pop && commit_cnt == LVL_WIDTH'(1))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    eligible = (state == DRAIN) && (commit_cnt != '0) && !empty;
  end
`else
  logic unused_ctl;

  assign unused_ctl = cpu_commit ^ frame_start;
  assign eligible   = !empty;
`endif

  always_comb begin
    ram_addr    = '0;
    ram_rd_en   = 1'b0;
    ram_wr_en   = 1'b0;
    ram_wr_data = '0;
    if (dsp_rd_en) begin
      ram_rd_en = 1'b1;
      ram_addr  = dsp_rd_addr;
    end else if (eligible) begin
      ram_wr_en   = 1'b1;
      ram_addr    = head.addr;
      ram_wr_data = head.data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      defer_count <= '0;
    else if (eligible && dsp_rd_en && defer_count != 16'hFFFF)
      defer_count <= defer_count + 16'd1;
  end
endmodule

// File: tb/tb_param_bus_arbiter.sv
// Bench for param_bus_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_param_bus_arbiter;
  localparam int W     = 36;
  localparam int AW    = 10;
  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          dsp_rd_en = 1'b0;
  logic [AW-1:0] dsp_rd_addr = '0;
  logic [W-1:0]  dsp_rd_data;
  logic          cpu_wr_valid = 1'b0;
  logic          cpu_wr_ready;
  logic [AW-1:0] cpu_wr_addr = '0;
  logic [W-1:0]  cpu_wr_data = '0;
  logic          cpu_commit = 1'b0;
  logic          frame_start = 1'b0;
  logic [AW-1:0] ram_addr;
  logic          ram_rd_en;
  logic          ram_wr_en;
  logic [W-1:0]  ram_wr_data;
  logic [W-1:0]  ram_rd_data = '0;
  logic [LW-1:0] fifo_level;
  logic [15:0]   defer_count;

  int total = 0;
  int bad = 0;

  param_bus_arbiter #(
    .PARAM_WIDTH(W), .PARAM_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .LVL_WIDTH(LW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .dsp_rd_en(dsp_rd_en), .dsp_rd_addr(dsp_rd_addr), .dsp_rd_data(dsp_rd_data),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
    .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_commit(cpu_commit), .frame_start(frame_start),
    .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
    .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data),
    .fifo_level(fifo_level), .defer_count(defer_count)
  );

  always #5 clk = ~clk;

  // Parameter RAM with 1-cycle read latency
  logic [W-1:0] bram [1024];
  always @(posedge clk) begin
    if (ram_wr_en) bram[ram_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= bram[ram_addr];
  end

  // Reference model: pending writes in acceptance order, expected RAM contents, deferral count
  typedef struct { logic [AW-1:0] a; logic [W-1:0] d; } wr_t;
  wr_t          mq[$];
  logic [W-1:0] mmem [1024];
  int           mdefer;
  logic [W-1:0] exp_rd;
  bit           exp_rd_vld;
  bit           e_wr;
  bit           e_ready;
  logic [AW-1:0] e_addr;
  logic [W-1:0]  e_wdata;

  function automatic logic [W-1:0] init_val(input int a);
    return {16'hBEEF, 10'(a), 10'(~a)};
  endfunction

  function automatic logic [W-1:0] pat(input int i);
    return {4'hC, 16'(i * 977), 16'(i ^ 16'h5A5A)};
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin
      bram[i] <= init_val(i);
      mmem[i] = init_val(i);
    end
  end

  task automatic model_clear();
    mq.delete();
    mdefer = 0;
    exp_rd_vld = 0;
  endtask

  task automatic step_pre(input logic rd, input logic [AW-1:0] ra, input logic wv,
                          input logic [AW-1:0] wa, input logic [W-1:0] wd);
    dsp_rd_en = rd; dsp_rd_addr = ra;
    cpu_wr_valid = wv; cpu_wr_addr = wa; cpu_wr_data = wd;
    @(negedge clk);
    e_ready = mq.size() < DEPTH;
    e_wr    = !rd && mq.size() != 0;
    e_addr  = rd ? ra : (e_wr ? mq[0].a : '0);
    e_wdata = e_wr ? mq[0].d : '0;
  endtask

  task automatic step_post();
    wr_t t;
    if (dsp_rd_en) exp_rd = mmem[dsp_rd_addr];
    exp_rd_vld = dsp_rd_en;
    if (dsp_rd_en && mq.size() != 0 && mdefer < 65535) mdefer++;
    if (e_wr) begin
      mmem[mq[0].a] = mq[0].d;
      void'(mq.pop_front());
    end
    if (cpu_wr_valid && e_ready) begin
      t.a = cpu_wr_addr; t.d = cpu_wr_data;
      mq.push_back(t);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    dsp_rd_en = 0; cpu_wr_valid = 0; cpu_commit = 0; frame_start = 0;
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    model_clear();
  endtask

  task automatic test_reset();
    reset_n = 0; #1;
    total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
    total++; if (cpu_wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cpu_wr_ready); end
    total++; if (defer_count !== 16'd0) begin bad++; $display("FAIL reset_defer got=%0d want=0", defer_count); end
    total++; if (ram_wr_en !== 1'b0 || ram_rd_en !== 1'b0 || ram_addr !== '0) begin
      bad++; $display("FAIL reset_port got wr=%b rd=%b addr=%h want 0/0/0", ram_wr_en, ram_rd_en, ram_addr); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    model_clear();
  endtask

  task automatic test_single_write();
    step_pre(0, '0, 1, 10'h010, 36'h1_2345_6789);
    total++; if (cpu_wr_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", cpu_wr_ready); end
    total++; if (ram_wr_en !== 1'b0) begin bad++; $display("FAIL single_early_wr got=%b want=0", ram_wr_en); end
    step_post();
    step_pre(0, '0, 0, '0, '0);
    total++; if (ram_wr_en !== 1'b1 || ram_addr !== 10'h010 || ram_wr_data !== 36'h1_2345_6789) begin
      bad++; $display("FAIL single_retire got wr=%b addr=%h data=%h want 1/010/123456789", ram_wr_en, ram_addr, ram_wr_data); end
    total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL single_level1 got=%0d want=1", fifo_level); end
    step_post();
    step_pre(0, '0, 0, '0, '0);
    total++; if (fifo_level !== 4'd0 || ram_wr_en !== 1'b0) begin
      bad++; $display("FAIL single_drained got level=%0d wr=%b want 0/0", fifo_level, ram_wr_en); end
    step_post();
  endtask

  task automatic test_defer_burst();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step_pre(1, 10'h3FF, 1, 10'(10'h040 + i), pat(i));
      step_post();
    end
    for (int i = 0; i < 20; i++) begin
      step_pre(1, 10'(i), 0, '0, '0);
      total++; if (ram_wr_en !== 1'b0) begin bad++; $display("FAIL burst_wr cyc=%0d got=%b want=0", i, ram_wr_en); end
      if (exp_rd_vld) begin
        total++; if (dsp_rd_data !== exp_rd) begin bad++; $display("FAIL burst_rd cyc=%0d got=%h want=%h", i, dsp_rd_data, exp_rd); end
      end
      step_post();
    end
    for (int i = 0; i < 3; i++) begin
      step_pre(0, '0, 0, '0, '0);
      if (i == 0) begin
        total++; if (defer_count !== 16'(mdefer) || defer_count !== 16'd22) begin
          bad++; $display("FAIL burst_defer got=%0d want=%0d", defer_count, mdefer); end
      end
      total++; if (ram_wr_en !== 1'b1 || ram_addr !== 10'(10'h040 + i) || ram_wr_data !== pat(i)) begin
        bad++; $display("FAIL burst_order idx=%0d got wr=%b addr=%h want 1/%h", i, ram_wr_en, ram_addr, 10'h040 + i); end
      step_post();
    end
    step_pre(0, '0, 0, '0, '0);
    total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL burst_level got=%0d want=0", fifo_level); end
    step_post();
  endtask

  task automatic test_fill();
    int sent = 0;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      step_pre(c < 11, 10'h005, sent < 9, 10'(10'h100 + sent), pat(100 + sent));
      total++; if (cpu_wr_ready !== e_ready) begin bad++; $display("FAIL fill_ready cyc=%0d got=%b want=%b", c, cpu_wr_ready, e_ready); end
      total++; if (fifo_level !== LW'(mq.size())) begin bad++; $display("FAIL fill_level cyc=%0d got=%0d want=%0d", c, fifo_level, mq.size()); end
      if (c == 8 || c == 11) begin
        total++; if (cpu_wr_ready !== 1'b0) begin bad++; $display("FAIL fill_full cyc=%0d got=%b want=0", c, cpu_wr_ready); end
      end
      if (exp_rd_vld) begin
        total++; if (dsp_rd_data !== exp_rd) begin bad++; $display("FAIL fill_rd cyc=%0d got=%h want=%h", c, dsp_rd_data, exp_rd); end
      end
      if (cpu_wr_valid && e_ready) sent++;
      step_post();
    end
    for (int c = 0; c < 10; c++) begin
      step_pre(0, '0, 0, '0, '0);
      step_post();
    end
    for (int i = 0; i < 9; i++) begin
      total++; if (bram[10'h100 + i] !== pat(100 + i)) begin
        bad++; $display("FAIL fill_lost idx=%0d got=%h want=%h", i, bram[10'h100 + i], pat(100 + i)); end
    end
  endtask

  task automatic test_stale_read();
    do_reset();
    step_pre(0, '0, 1, 10'h020, 36'h0_0000_0AAA); step_post();
    step_pre(0, '0, 0, '0, '0); step_post();
    step_pre(0, '0, 0, '0, '0); step_post();
    step_pre(1, 10'h020, 1, 10'h020, 36'h0_0000_0BBB);
    total++; if (cpu_wr_ready !== 1'b1) begin bad++; $display("FAIL stale_ready got=%b want=1", cpu_wr_ready); end
    step_post();
    step_pre(0, '0, 0, '0, '0);
    total++; if (dsp_rd_data !== 36'h0_0000_0AAA) begin bad++; $display("FAIL stale_old got=%h want=aaa", dsp_rd_data); end
    total++; if (ram_wr_en !== 1'b1 || ram_addr !== 10'h020) begin
      bad++; $display("FAIL stale_wr got wr=%b addr=%h want 1/020", ram_wr_en, ram_addr); end
    step_post();
    total++; if (bram[10'h020] !== 36'h0_0000_0BBB) begin bad++; $display("FAIL stale_new got=%h want=bbb", bram[10'h020]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step_pre(1, 10'h001, 1, 10'(10'h200 + i), pat(200 + i));
      step_post();
    end
    dsp_rd_en = 0; cpu_wr_valid = 0;
    reset_n = 0; #1;
    total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL mid_level got=%0d want=0", fifo_level); end
    total++; if (cpu_wr_ready !== 1'b1 || ram_wr_en !== 1'b0) begin
      bad++; $display("FAIL mid_port got ready=%b wr=%b want 1/0", cpu_wr_ready, ram_wr_en); end
    @(posedge clk); #1 reset_n = 1;
    model_clear();
    for (int c = 0; c < 6; c++) begin
      step_pre(0, '0, 0, '0, '0);
      total++; if (ram_wr_en !== 1'b0) begin bad++; $display("FAIL mid_ghost cyc=%0d got=%b want=0", c, ram_wr_en); end
      step_post();
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (bram[10'h200 + i] !== init_val(10'h200 + i)) begin
        bad++; $display("FAIL mid_ram idx=%0d got=%h want=%h", i, bram[10'h200 + i], init_val(10'h200 + i)); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      int rd_pct = (c < 300) ? 75 : 30;
      logic [W-1:0] d = W'({$urandom(), $urandom()});
      step_pre($urandom_range(0, 99) < rd_pct, 10'($urandom_range(0, 15)),
               $urandom_range(0, 99) < 60, 10'($urandom_range(0, 15)), d);
      total++; if (ram_rd_en !== dsp_rd_en || ram_wr_en !== e_wr || ram_addr !== e_addr) begin
        bad++; $display("FAIL rnd_port cyc=%0d got rd=%b wr=%b addr=%h want %b/%b/%h", c, ram_rd_en, ram_wr_en, ram_addr, dsp_rd_en, e_wr, e_addr); end
      if (e_wr) begin
        total++; if (ram_wr_data !== e_wdata) begin bad++; $display("FAIL rnd_wdata cyc=%0d got=%h want=%h", c, ram_wr_data, e_wdata); end
      end
      total++; if (cpu_wr_ready !== e_ready || fifo_level !== LW'(mq.size())) begin
        bad++; $display("FAIL rnd_fifo cyc=%0d got ready=%b lvl=%0d want %b/%0d", c, cpu_wr_ready, fifo_level, e_ready, mq.size()); end
      total++; if (defer_count !== 16'(mdefer)) begin bad++; $display("FAIL rnd_defer cyc=%0d got=%0d want=%0d", c, defer_count, mdefer); end
      if (exp_rd_vld) begin
        total++; if (dsp_rd_data !== exp_rd) begin bad++; $display("FAIL rnd_rd cyc=%0d got=%h want=%h", c, dsp_rd_data, exp_rd); end
      end
      step_post();
    end
    for (int c = 0; c < 12; c++) begin
      step_pre(0, '0, 0, '0, '0);
      step_post();
    end
    for (int a = 0; a < 16; a++) begin
      total++; if (bram[a] !== mmem[a]) begin bad++; $display("FAIL rnd_ram addr=%0d got=%h want=%h", a, bram[a], mmem[a]); end
    end
  endtask

`ifdef PARAM_ATOMIC_COMMIT_EN
  task automatic test_atomic_commit();
    int nwr = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step_pre(0, '0, 1, 10'(10'h300 + i), pat(300 + i));
      if (ram_wr_en) nwr++;
      step_post();
    end
    cpu_commit = 1;
    step_pre(0, '0, 0, '0, '0); if (ram_wr_en) nwr++; step_post();
    cpu_commit = 0;
    for (int i = 3; i < 5; i++) begin
      step_pre(0, '0, 1, 10'(10'h300 + i), pat(300 + i));
      if (ram_wr_en) nwr++;
      step_post();
    end
    for (int c = 0; c < 3; c++) begin
      step_pre(0, '0, 0, '0, '0); if (ram_wr_en) nwr++; step_post();
    end
    total++; if (nwr !== 0) begin bad++; $display("FAIL atomic_early got=%0d want=0", nwr); end
    frame_start = 1;
    step_pre(0, '0, 0, '0, '0); if (ram_wr_en) nwr++; step_post();
    frame_start = 0;
    for (int c = 0; c < 10; c++) begin
      step_pre(0, '0, 0, '0, '0); if (ram_wr_en) nwr++; step_post();
    end
    total++; if (nwr !== 3) begin bad++; $display("FAIL atomic_count got=%0d want=3", nwr); end
    total++; if (fifo_level !== 4'd2) begin bad++; $display("FAIL atomic_level got=%0d want=2", fifo_level); end
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] want = (i < 3) ? pat(300 + i) : init_val(10'h300 + i);
      total++; if (bram[10'h300 + i] !== want) begin bad++; $display("FAIL atomic_ram idx=%0d got=%h want=%h", i, bram[10'h300 + i], want); end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef PARAM_ATOMIC_COMMIT_EN
    test_atomic_commit();
`else
    test_single_write();
    test_defer_burst();
    test_fill();
    test_stale_read();
    test_reset_mid();
    test_random();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
